// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

endpackage

// File: rtl/seg7_scan_ctrl_tick.sv
// Terminal tick counter: counts 0..limit, wraps to 0 after limit, clear has priority.
module scan_tick #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display with
// inter-digit blanking; drives the external 8:1 mux select and captures its data.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 50000,
    parameter int BLANK_TICKS     = 1000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] digit_mask,
    output logic [2:0] mux_sel,
    input  logic [7:0] mux_data,
    output logic [7:0] seg_n,
    output logic [7:0] an_n,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] SHOW_LIM  = CNT_W'(TICKS_PER_DIGIT - 1);

    scan_state_t state, state_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  seg_d, an_d;
    logic        fd_d;
    logic        tick_last;
    logic        tick_clear;
    logic [CNT_W-1:0] tick_limit;

    assign mux_sel    = idx;
    assign tick_clear = !en || (state == IDLE);
    assign tick_limit = (state == SHOW) ? SHOW_LIM : BLANK_LIM;

    scan_tick #(.CNT_W(CNT_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .en    (1'b1),
        .limit (tick_limit),
        .last  (tick_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            seg_n      <= SEG_BLANK;
            an_n       <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            seg_n      <= seg_d;
            an_n       <= an_d;
            frame_done <= fd_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        seg_d   = seg_n;
        an_d    = an_n;
        fd_d    = 1'b0;
        if (!en) begin
            // Dropping enable wins over every other transition.
            state_d = IDLE;
            idx_d   = '0;
            seg_d   = SEG_BLANK;
            an_d    = SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    state_d = BLANK;
                end
                BLANK: begin
                    if (tick_last) begin
                        seg_d   = ~mux_data;
                        an_d    = digit_mask[idx] ? ~(8'h01 << idx) : SEG_BLANK;
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (tick_last) begin
                        an_d    = SEG_BLANK;
                        idx_d   = idx + 3'd1;
                        fd_d    = (idx == 3'(NUM_DIGITS - 1));
                        state_d = BLANK;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    seg_d   = SEG_BLANK;
                    an_d    = SEG_BLANK;
                end
            endcase
        end
    end

endmodule
